// File: rtl/spi_transaction_ctrl.sv
// spi_transaction_ctrl
// Frames a transaction of 1..255 bytes around a byte-level SPI mode-3 engine.
// Chip select stays asserted for the whole transaction, with programmable
// setup, hold and deselect gaps around it. Transmit bytes arrive on a
// valid/ready stream. Each received byte leaves as a one-cycle valid pulse.
// If the engine stops answering, a per-byte timeout aborts the transaction,
// and the abort is reported on err together with done.
module spi_transaction_ctrl #(
    parameter logic [15:0] CS_SETUP_CYCLES = 16'd16,
    parameter logic [15:0] CS_HOLD_CYCLES  = 16'd16,
    parameter logic [15:0] CS_GAP_CYCLES   = 16'd4,
    parameter logic [19:0] TIMEOUT_CYCLES  = 20'hFFFFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] len,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic [7:0] spi_send_data,
    output logic       spi_begin,
    output logic       spi_ss,
    input  logic [7:0] spi_rx_data,
    input  logic       spi_end
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WAIT_TX,
        ST_ISSUE,
        ST_WAIT_END,
        ST_HOLD,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t      state, state_d;
    logic [7:0]  remaining, remaining_d;
    logic [15:0] phase_cnt, phase_cnt_d;   // setup / hold / gap timing
    logic [19:0] tmo_cnt, tmo_cnt_d;       // per-byte wait for spi_end
    logic        abort, abort_d;           // sticky until DONE

    logic       busy_d, done_d, err_d, tx_ready_d, rx_valid_d;
    logic       spi_begin_d, spi_ss_d;
    logic [7:0] rx_data_d, spi_send_data_d;

    // Register all state and outputs; a synchronous reset returns everything to idle.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            remaining     <= 8'h00;
            phase_cnt     <= 16'h0000;
            tmo_cnt       <= 20'h00000;
            abort         <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            tx_ready      <= 1'b0;
            rx_data       <= 8'h00;
            rx_valid      <= 1'b0;
            spi_send_data <= 8'h00;
            spi_begin     <= 1'b0;
            spi_ss        <= 1'b1;
        end else begin
            state         <= state_d;
            remaining     <= remaining_d;
            phase_cnt     <= phase_cnt_d;
            tmo_cnt       <= tmo_cnt_d;
            abort         <= abort_d;
            busy          <= busy_d;
            done          <= done_d;
            err           <= err_d;
            tx_ready      <= tx_ready_d;
            rx_data       <= rx_data_d;
            rx_valid      <= rx_valid_d;
            spi_send_data <= spi_send_data_d;
            spi_begin     <= spi_begin_d;
            spi_ss        <= spi_ss_d;
        end
    end

    // Next-state and next-output logic for the transaction sequencer.
    always_comb begin
        // NOTE: every signal gets a default before the case, so no path can infer a latch.
        state_d         = state;
        remaining_d     = remaining;
        phase_cnt_d     = 16'h0000;
        tmo_cnt_d       = tmo_cnt;
        abort_d         = abort;
        busy_d          = busy;
        done_d          = 1'b0;
        err_d           = 1'b0;
        tx_ready_d      = tx_ready;
        rx_data_d       = rx_data;
        rx_valid_d      = 1'b0;
        spi_send_data_d = spi_send_data;
        spi_begin_d     = 1'b0;
        spi_ss_d        = spi_ss;

        case (state)
            ST_IDLE: begin
                // A zero-length request is dropped without any response.
                if (start && (len != 8'h00)) begin
                    remaining_d = len;
                    spi_ss_d    = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if (phase_cnt == CS_SETUP_CYCLES - 16'd1) begin
                    tx_ready_d = 1'b1;
                    state_d    = ST_WAIT_TX;
                end else begin
                    phase_cnt_d = phase_cnt + 16'd1;
                end
            end

            ST_WAIT_TX: begin
                // Wait for the next byte for as long as it takes, with chip select held low.
                if (tx_valid && tx_ready) begin
                    spi_send_data_d = tx_data;
                    tx_ready_d      = 1'b0;
                    spi_begin_d     = 1'b1;
                    state_d         = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                // spi_begin is high for this one cycle only.
                tmo_cnt_d = 20'h00000;
                state_d   = ST_WAIT_END;
            end

            ST_WAIT_END: begin
                if (spi_end) begin
                    rx_data_d  = spi_rx_data;
                    rx_valid_d = 1'b1;
                    if (remaining != 8'h00) begin
                        remaining_d = remaining - 8'd1;
                    end
                    if (remaining == 8'd1) begin
                        state_d = ST_HOLD;
                    end else begin
                        tx_ready_d = 1'b1;
                        state_d    = ST_WAIT_TX;
                    end
                end else if (tmo_cnt == TIMEOUT_CYCLES - 20'd1) begin
                    // After an abort, no more bytes are requested.
                    abort_d = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    tmo_cnt_d = tmo_cnt + 20'd1;
                end
            end

            ST_HOLD: begin
                if (phase_cnt == CS_HOLD_CYCLES - 16'd1) begin
                    spi_ss_d = 1'b1;
                    state_d  = ST_GAP;
                end else begin
                    phase_cnt_d = phase_cnt + 16'd1;
                end
            end

            ST_GAP: begin
                // Chip select high long enough for the engine to return to idle.
                if (phase_cnt == CS_GAP_CYCLES - 16'd1) begin
                    done_d  = 1'b1;
                    err_d   = abort;
                    state_d = ST_DONE;
                end else begin
                    phase_cnt_d = phase_cnt + 16'd1;
                end
            end

            ST_DONE: begin
                busy_d  = 1'b0;
                abort_d = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_transaction_ctrl.sv
// tb_spi_transaction_ctrl
// Self-checking bench for spi_transaction_ctrl. A behavioural engine model
// answers each spi_begin after a random delay. Expected rx bytes, byte
// counts and frame timing come from the transaction plan and simple edge
// arithmetic.
module tb_spi_transaction_ctrl;

    localparam int SETUP = 16;
    localparam int HOLD  = 16;
    localparam int GAP   = 4;
    localparam int TMO   = 100;
    localparam int STALL = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] len;
    logic       busy, done, err;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] spi_send_data;
    logic       spi_begin, spi_ss;
    logic [7:0] spi_rx_data;
    logic       spi_end;

    spi_transaction_ctrl #(
        .CS_SETUP_CYCLES(16'(SETUP)),
        .CS_HOLD_CYCLES (16'(HOLD)),
        .CS_GAP_CYCLES  (16'(GAP)),
        .TIMEOUT_CYCLES (20'(TMO))
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .len          (len),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .spi_send_data(spi_send_data),
        .spi_begin    (spi_begin),
        .spi_ss       (spi_ss),
        .spi_rx_data  (spi_rx_data),
        .spi_end      (spi_end)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Bench state: the plan, the tx stream, the engine model and the per-transaction log.
    logic [7:0] plan[$];
    logic [7:0] txq[$];
    logic [7:0] sent_q[$];
    logic [7:0] rx_q[$];
    int         resp_mode;
    logic [7:0] key;
    bit         eng_busy, mute, spur, stall_done, prev_ready, prev_ss;
    int         eng_wait;
    logic [7:0] eng_resp;
    int edge_no, start_edge, last_end_edge, hs_edge, first_ready_edge, ss_rise_edge, done_edge;
    int n_begin, n_done, n_err_done, n_err_stray, n_ss_rise, n_hs;
    int begin_ss_bad, begin_lat_bad, rx_lat_bad, ready_lat_bad;
    int stall_idx, stall_left, stall_ready;

    // Engine response: loopback, fixed value, or xor with a per-transaction key.
    function automatic logic [7:0] resp_of(input logic [7:0] b);
        case (resp_mode)
            0:       return b;
            1:       return 8'h3C;
            default: return b ^ key;
        endcase
    endfunction

    task automatic clear_stats();
        txq.delete(); sent_q.delete(); rx_q.delete();
        eng_busy = 0; mute = 0; spur = 0; stall_done = 0;
        tx_valid = 0; spi_end = 0;
        start_edge = -1; last_end_edge = -1; hs_edge = -1;
        first_ready_edge = -1; ss_rise_edge = -1; done_edge = -1;
        n_begin = 0; n_done = 0; n_err_done = 0; n_err_stray = 0; n_ss_rise = 0; n_hs = 0;
        begin_ss_bad = 0; begin_lat_bad = 0; rx_lat_bad = 0; ready_lat_bad = 0;
        stall_idx = -1; stall_left = 0; stall_ready = 0;
        prev_ready = tx_ready; prev_ss = spi_ss;
    endtask

    // One clock: log what the edge consumed, observe outputs 1 ns later, then drive the next inputs.
    task automatic tick();
        bit hs, end_now;
        hs      = tx_valid && tx_ready;
        end_now = spi_end;
        @(posedge clk);
        edge_no++;
        if (hs && !rst) begin
            void'(txq.pop_front());
            hs_edge = edge_no;
            n_hs++;
        end
        if (end_now && !rst) begin
            last_end_edge = edge_no;
            eng_busy = 0;
        end
        #1;
        if (spi_begin) begin
            n_begin++;
            sent_q.push_back(spi_send_data);
            if (spi_ss) begin_ss_bad++;
            if (edge_no != hs_edge) begin_lat_bad++;
            eng_busy = 1;
            eng_wait = $urandom_range(30, 1);
            eng_resp = resp_of(spi_send_data);
        end
        if (rx_valid) begin
            rx_q.push_back(rx_data);
            if (edge_no != last_end_edge) rx_lat_bad++;
        end
        if (tx_ready && !prev_ready) begin
            if (first_ready_edge < 0) first_ready_edge = edge_no;
            else if (edge_no != last_end_edge) ready_lat_bad++;
        end
        if (done) begin
            n_done++;
            done_edge = edge_no;
            if (err) n_err_done++;
        end
        if (err && !done) n_err_stray++;
        if (spi_ss && !prev_ss) begin
            n_ss_rise++;
            ss_rise_edge = edge_no;
        end
        prev_ready = tx_ready;
        prev_ss    = spi_ss;
        // engine model
        spi_end = 0;
        if (eng_busy && !mute) begin
            if (eng_wait == 0) begin
                spi_end     = 1;
                spi_rx_data = eng_resp;
            end else begin
                eng_wait--;
            end
        end
        // tx source, optionally withholding one byte
        if (!stall_done && tx_ready && n_hs == stall_idx) begin
            stall_left = STALL;
            stall_done = 1;
        end
        if (stall_left > 0) begin
            if (tx_ready && spi_ss == 1'b0) stall_ready++;
            stall_left--;
        end
        tx_valid = (txq.size() > 0) && (stall_left == 0);
        tx_data  = (txq.size() > 0) ? txq[0] : 8'h00;
        // start requests while busy must be ignored
        start = 0;
        if (spur && busy && ($urandom_range(3, 0) == 0)) begin
            start = 1;
            len   = 8'($urandom_range(255, 0));
        end
    endtask

    task automatic run_txn(input string name, input int n, input int st_idx, input bit sp);
        clear_stats();
        stall_idx = st_idx;
        spur      = sp;
        txq       = plan;
        len       = 8'(n);
        start     = 1;
        tick();
        start_edge = edge_no;
        check({name, ":busy_on_accept"}, busy, 1);
        check({name, ":ss_on_accept"}, spi_ss, 0);
        for (int i = 0; i < 4000 && n_done == 0; i++) tick();
        spur = 0;
        tick();
        check({name, ":busy_after_done"}, busy, 0);
        for (int i = 0; i < 3; i++) tick();
        check({name, ":done_count"}, n_done, 1);
        check({name, ":err"}, n_err_done + n_err_stray, 0);
        check({name, ":begin_count"}, n_begin, n);
        check({name, ":rx_count"}, rx_q.size(), n);
        for (int i = 0; i < rx_q.size() && i < plan.size(); i++)
            check($sformatf("%s:rx%0d", name, i), rx_q[i], resp_of(plan[i]));
        for (int i = 0; i < sent_q.size() && i < plan.size(); i++)
            check($sformatf("%s:tx%0d", name, i), sent_q[i], plan[i]);
        check({name, ":first_ready"}, first_ready_edge, start_edge + SETUP);
        check({name, ":ss_rise_count"}, n_ss_rise, 1);
        check({name, ":ss_rise_edge"}, ss_rise_edge, last_end_edge + HOLD);
        check({name, ":done_edge"}, done_edge, last_end_edge + HOLD + GAP);
        check({name, ":timing_faults"}, begin_ss_bad + begin_lat_bad + rx_lat_bad + ready_lat_bad, 0);
        if (st_idx >= 0) check({name, ":stall_ready"}, stall_ready, STALL);
    endtask

    task automatic run_timeout();
        bit ok;
        clear_stats();
        plan  = '{8'h11, 8'h22};
        txq   = plan;
        mute  = 1;
        len   = 8'd2;
        start = 1;
        tick();
        for (int i = 0; i < 4000 && n_done == 0; i++) tick();
        tick();
        check("tmo:busy_after_done", busy, 0);
        check("tmo:done_count", n_done, 1);
        check("tmo:err_with_done", n_err_done, 1);
        check("tmo:err_stray", n_err_stray, 0);
        check("tmo:rx_count", rx_q.size(), 0);
        check("tmo:begin_count", n_begin, 1);
        check("tmo:handshakes", n_hs, 1);
        check("tmo:gap_len", done_edge - ss_rise_edge, GAP);
        ok = (ss_rise_edge >= hs_edge + TMO + HOLD) && (ss_rise_edge <= hs_edge + TMO + HOLD + 2);
        check("tmo:ss_release_time", ok, 1);
        mute = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; start = 0; len = 0; tx_valid = 0; tx_data = 0;
        spi_end = 0; spi_rx_data = 0; edge_no = 0; resp_mode = 0; key = 0;
        stall_idx = -1; stall_left = 0;
        tick(); tick();
        check("rst:ss", spi_ss, 1);
        check("rst:busy_done_err", {busy, done, err}, 0);
        check("rst:ready_rxv_begin", {tx_ready, rx_valid, spi_begin}, 0);
        check("rst:rx_data", rx_data, 8'h00);
        check("rst:send_data", spi_send_data, 8'h00);
        rst = 0;
        tick(); tick();

        // Single byte with a fixed engine response.
        resp_mode = 1;
        plan = '{8'hA5};
        run_txn("single", 1, -1, 0);

        // Four-byte burst with a loopback engine.
        resp_mode = 0;
        plan = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_txn("burst", 4, -1, 0);

        // Second byte withheld for STALL cycles.
        plan = '{8'h5E, 8'hC7};
        run_txn("underrun", 2, 1, 0);

        // A zero-length request is ignored.
        clear_stats();
        len = 8'd0; start = 1;
        tick();
        check("len0:busy", busy, 0);
        check("len0:ss", spi_ss, 1);
        for (int i = 0; i < 40; i++) tick();
        check("len0:done_count", n_done, 0);
        check("len0:no_ready", first_ready_edge, -1);

        // start pulses while busy are ignored.
        resp_mode = 2; key = 8'h96;
        plan = '{8'h10, 8'h20, 8'h30};
        run_txn("busy_start", 3, -1, 1);

        run_timeout();

        // Reset while byte 2 of 3 is in flight.
        resp_mode = 0;
        clear_stats();
        plan = '{8'hAA, 8'hBB, 8'hCC};
        txq = plan;
        len = 8'd3; start = 1;
        tick();
        for (int i = 0; i < 2000 && n_begin < 2; i++) tick();
        rst = 1;
        tick();
        rst = 0;
        eng_busy = 0; spi_end = 0; txq.delete(); tx_valid = 0;
        check("mid_rst:ss", spi_ss, 1);
        check("mid_rst:busy", busy, 0);
        check("mid_rst:tx_ready", tx_ready, 0);
        check("mid_rst:pulses", {done, err, rx_valid, spi_begin}, 0);
        check("mid_rst:rx_data", rx_data, 8'h00);
        for (int i = 0; i < 40; i++) tick();
        check("mid_rst:no_done", n_done, 0);
        check("mid_rst:rx_count", rx_q.size(), 1);
        plan = '{8'h42};
        run_txn("post_rst", 1, -1, 0);

        // Randomised transactions against the xor-engine model.
        for (int k = 0; k < 6; k++) begin
            int n;
            resp_mode = 2;
            key = 8'($urandom);
            n = $urandom_range(6, 1);
            plan.delete();
            for (int i = 0; i < n; i++) plan.push_back(8'($urandom));
            run_txn($sformatf("rnd%0d", k), n, -1, 1'($urandom_range(1, 0)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_transaction_ctrl.md
# spi_transaction_ctrl

Multi-byte SPI transaction sequencer that sits directly upstream of the team's byte-level SPI mode-3 engine. It drives the engine's `send_data`/`begin_transmission`/`slave_select` inputs and consumes its `recieved_data`/`end_transmission` outputs. It frames one transaction of 1..255 bytes under a single chip-select assertion, with programmable setup, hold and deselect gaps. Transmit bytes arrive on a valid/ready stream, and received bytes leave as one-cycle valid pulses.

## Interface
- `CS_SETUP_CYCLES`, default 16: cycles `spi_ss` is low before the first byte is issued (≥1).
- `CS_HOLD_CYCLES`, default 16: cycles `spi_ss` stays low after the last `spi_end` (≥1).
- `CS_GAP_CYCLES`, default 4: minimum cycles `spi_ss` is high before the next transaction (≥2).
- `TIMEOUT_CYCLES`, default 20'hFFFFF: maximum cycles to wait for `spi_end` per byte; width 20.
- Ports:
  - `clk`, in, 1: clock.
  - `rst`, in, 1: reset, synchronous, active-high.
  - `start`, in, 1: request a transaction; sampled only in IDLE.
  - `len`, in, 8: byte count, sampled with `start`; 0 means the request is ignored.
  - `busy`, out, 1: high from the cycle after an accepted start until DONE exits.
  - `done`, out, 1: one-cycle pulse at the end of a transaction.
  - `err`, out, 1: one-cycle pulse coincident with `done` when the transaction was aborted by timeout.
  - `tx_data`, in, 8: next byte to send.
  - `tx_valid`, in, 1: `tx_data` valid.
  - `tx_ready`, out, 1: controller accepts `tx_data`.
  - `rx_data`, out, 8: received byte.
  - `rx_valid`, out, 1: one-cycle pulse; `rx_data` valid. There is no backpressure.
  - `spi_send_data`, out, 8: to the engine's `send_data`.
  - `spi_begin`, out, 1: to the engine's `begin_transmission`.
  - `spi_ss`, out, 1: to the engine's `slave_select` and the pad. Active-low; 1 means deselected.
  - `spi_rx_data`, in, 8: from the engine's `recieved_data`.
  - `spi_end`, in, 1: from the engine's `end_transmission`, a one-cycle pulse.

## Operation
- All outputs are registered.
- Reset values:
  - `spi_ss`=1.
  - `busy`=`done`=`err`=`tx_ready`=`rx_valid`=`spi_begin`=0.
  - `rx_data`=`spi_send_data`=8'h00.
  - State is IDLE and all counters are 0.
- States: IDLE, SETUP, WAIT_TX, ISSUE, WAIT_END, HOLD, GAP, DONE.
- IDLE:
  - `start`=1 with `len`≠0: latch `len` into `remaining`, set `spi_ss`=0 and `busy`=1, go to SETUP.
  - `start`=1 with `len`=0: ignored; stay in IDLE, no `done`.
- SETUP: count CS_SETUP_CYCLES, then go to WAIT_TX.
- WAIT_TX:
  - `tx_ready`=1.
  - On `tx_valid`&`tx_ready`, register `tx_data` into `spi_send_data`, drop `tx_ready`, go to ISSUE.
  - Waits indefinitely, with `spi_ss` held low.
- ISSUE: `spi_begin`=1 for exactly one cycle, clear the timeout counter, go to WAIT_END.
- WAIT_END:
  - On `spi_end`: capture `spi_rx_data` into `rx_data`, pulse `rx_valid` the next cycle, decrement `remaining`.
  - If `remaining` was 1, go to HOLD; otherwise go to WAIT_TX.
  - `spi_ss` stays 0 between bytes, so the engine's hold state accepts the next `begin`.
- Timeout: if the counter reaches TIMEOUT_CYCLES in WAIT_END, set the sticky abort flag and go to HOLD; remaining bytes are not requested.
- HOLD: count CS_HOLD_CYCLES, then set `spi_ss`=1 and go to GAP.
- GAP: count CS_GAP_CYCLES with `spi_ss`=1 (this returns the engine to its idle state), then go to DONE.
- DONE: one cycle.
  - `done`=1, and `err`=abort flag.
  - `busy`=0 from the next cycle; clear the abort flag; go to IDLE.
- Counters:
  - `remaining` is 8-bit and never wraps; it decrements only on `spi_end` in WAIT_END.
  - Gap/setup/hold counters are 16-bit and reset on each state entry.
- `spi_end` outside WAIT_END is ignored.
- `start` while `busy` is ignored, with no queuing.
- Reset mid-transaction: on the next edge `spi_ss`=1 and all outputs take their reset values. No `done` and no `rx_valid` are emitted for the partial byte.

## Timing
- `start` accepted at edge T: `busy`=1 and `spi_ss`=0 at T+1.
- First `tx_ready` at T+1+CS_SETUP_CYCLES.
- TX handshake at edge H: `spi_begin`=1 during H+1 only, with `spi_send_data` stable from H+1 until the next handshake.
- `spi_end` at edge E:
  - `rx_valid`=1 and `rx_data` valid during E+1.
  - Next `tx_ready` at E+1, if bytes remain.
- Last `spi_end` at E: `spi_ss`=1 at E+1+CS_HOLD_CYCLES.
- `done` at E+1+CS_HOLD_CYCLES+CS_GAP_CYCLES.
- Earliest next accepted `start` is the cycle after `done`.
- `spi_begin` never asserts while `spi_ss`=1.

## Test plan
- Single byte: `len`=1, tx 8'hA5, engine model returns 8'h3C → one `spi_begin` pulse, `rx_data`=8'h3C with `rx_valid`, `spi_ss` low for the whole byte, `done` with `err`=0, timing exact per above.
- Burst: `len`=4, tx 01,02,03,04, loopback model → `rx_valid` ×4 with 01..04 in order, exactly 4 `spi_begin` pulses, `spi_ss` never high between bytes.
- TX underrun: `len`=2, `tx_valid` withheld 50 cycles before byte 2 → `tx_ready` held, `spi_ss` stays 0, no extra `spi_begin`, completes normally.
- Ignored requests: `start` with `len`=0; `start` while `busy` → no state change, no `done`, byte count unaffected.
- Timeout: TIMEOUT_CYCLES=100, model never asserts `spi_end` → `done` and `err` pulse together, no `rx_valid`, `spi_ss` returns 1 after hold.
- Reset mid-burst: `rst` during byte 2 of 3 → next cycle `spi_ss`=1, `busy`=0, `tx_ready`=0; a new `len`=1 transaction afterwards completes cleanly.
